// File: rtl/sgl2ext_convert_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sgl2ext_convert_mc_pkg
// Brief    : Shared widths, constants and types for the single-to-extended
//            multi-channel converter.
// Revision : 1.0 - initial release
// ============================================================================
package sgl2ext_convert_mc_pkg;

    localparam int SGL_W          = 32;
    localparam int SGL_EXP_W      = 8;
    localparam int SGL_MAN_W      = 23;
    localparam int EXT_W          = 43;
    localparam int EXT_EXP_W      = 11;
    localparam int EXT_MAN_W      = 31;
    localparam int EXT_BIAS_DELTA = 896;
    localparam logic [EXT_EXP_W-1:0] EXT_EXP_MAX = 11'h7FF;
    localparam int LZ_W           = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } cls_t;

endpackage
`default_nettype wire

// File: rtl/sgl2ext_convert_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : sgl2ext_convert_mc_if
// Brief    : Batch control and data bundle of the multi-channel converter.
// Revision : 1.0 - initial release
// ============================================================================
interface sgl2ext_convert_mc_if #(
    parameter int NCH = 4
);
    logic              ena;
    logic              sta;
    logic [NCH*32-1:0] x;
    logic [NCH*43-1:0] y;
    logic              busy;
    logic              done_sig;
    logic              sta_err;

    modport master (output ena, sta, x, input y, busy, done_sig, sta_err);
    modport slave  (input ena, sta, x, output y, busy, done_sig, sta_err);
endinterface
`default_nettype wire

// File: rtl/sgl2ext_convert_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : sgl2ext_core
// Brief    : Two-stage IEEE single to 43-bit extended-single widening pipe
//            with valid/tag sideband; exact, no rounding.
// Revision : 1.0 - initial release
// ============================================================================
module sgl2ext_core
    import sgl2ext_convert_mc_pkg::*;
#(
    parameter int TAG_W       = 2,
    parameter int DENORM_NORM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [SGL_W-1:0] in_data,
    output logic             s1_busy,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [EXT_W-1:0] out_data
);

    function automatic logic [LZ_W-1:0] lzc(input logic [SGL_MAN_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = '0;
        for (int i = 0; i < SGL_MAN_W; i++)
            if (v[i]) n = LZ_W'(SGL_MAN_W - 1 - i);
        return n;
    endfunction

    logic [SGL_EXP_W-1:0] in_exp;
    logic [SGL_MAN_W-1:0] in_man;
    cls_t                 in_cls;

    assign in_exp = in_data[SGL_W-2 -: SGL_EXP_W];
    assign in_man = in_data[SGL_MAN_W-1:0];

    always_comb begin
        in_cls = CLS_NORMAL;
        if (in_exp == '0)      in_cls = (in_man == '0) ? CLS_ZERO : CLS_DENORM;
        else if (in_exp == '1) in_cls = (in_man == '0) ? CLS_INF  : CLS_NAN;
    end

    logic                 s1_valid;
    logic [TAG_W-1:0]     s1_tag;
    logic                 s1_sign;
    logic [SGL_EXP_W-1:0] s1_exp;
    logic [SGL_MAN_W-1:0] s1_man;
    cls_t                 s1_cls;
    logic [LZ_W-1:0]      s1_lz;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_cls   <= CLS_ZERO;
            s1_lz    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            s1_sign  <= in_data[SGL_W-1];
            s1_exp   <= in_exp;
            s1_man   <= in_man;
            s1_cls   <= in_cls;
            s1_lz    <= lzc(in_man);
        end
    end

    logic [EXT_EXP_W-1:0] pk_exp;
    logic [EXT_MAN_W-1:0] pk_man;
    logic [SGL_MAN_W-1:0] dn_man;

    // Shifting one past the leading one drops the hidden bit.
    assign dn_man = s1_man << (s1_lz + LZ_W'(1));

    always_comb begin
        pk_exp = '0;
        pk_man = '0;
        case (s1_cls)
            CLS_NORMAL: begin
                pk_exp = {3'b000, s1_exp} + EXT_EXP_W'(EXT_BIAS_DELTA);
                pk_man = {s1_man, 8'h00};
            end
            CLS_DENORM: begin
                if (DENORM_NORM != 0) begin
                    pk_exp = EXT_EXP_W'(EXT_BIAS_DELTA) - {6'd0, s1_lz};
                    pk_man = {dn_man, 8'h00};
                end
            end
            CLS_INF: pk_exp = EXT_EXP_MAX;
            CLS_NAN: begin
                pk_exp = EXT_EXP_MAX;
                pk_man = {s1_man, 8'h00} | 31'h4000_0000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_tag   <= s1_tag;
            out_data  <= {s1_sign, pk_exp, pk_man};
        end
    end

    assign s1_busy = s1_valid;

endmodule
`default_nettype wire

// File: rtl/sgl2ext_convert_mc.sv
`default_nettype none
// ============================================================================
// Module   : sgl2ext_convert_mc
// Brief    : Batch converter: captures NCH singles on sta, converts them
//            serially through one shared core into a registered result bank.
// Revision : 1.0 - initial release
// ============================================================================
module sgl2ext_convert_mc
    import sgl2ext_convert_mc_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DENORM_NORM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sgl2ext_convert_mc_if.slave  bus
);

    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NCH - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             busy_ff, busy_nx;
    logic             done_ff, done_nx;
    logic             err_ff, err_nx;
    logic             capture, issue;

    logic [SGL_W-1:0] cap   [NCH];
    logic [EXT_W-1:0] ybank [NCH];

    logic             s1_busy, res_valid;
    logic [CNT_W-1:0] res_tag;
    logic [EXT_W-1:0] res_data;
    logic             drain_done;

    assign drain_done = !s1_busy && res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy_ff <= 1'b0;
            done_ff <= 1'b0;
            err_ff  <= 1'b0;
        end else if (bus.ena) begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            busy_ff <= busy_nx;
            done_ff <= done_nx;
            err_ff  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_nx  = busy_ff;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        capture  = 1'b0;
        issue    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.sta) begin
                    state_nx = ST_ISSUE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    capture  = 1'b1;
                end
            end
            ST_ISSUE: begin
                issue  = 1'b1;
                err_nx = bus.sta;
                if (cnt == LAST_CH) state_nx = ST_DRAIN;
                else                cnt_nx   = cnt + CNT_W'(1);
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                    // A start on the completing edge chains the next batch.
                    if (bus.sta) begin
                        state_nx = ST_ISSUE;
                        cnt_nx   = '0;
                        busy_nx  = 1'b1;
                        capture  = 1'b1;
                    end
                end else begin
                    err_nx = bus.sta;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cap[c]   <= '0;
                ybank[c] <= '0;
            end
        end else if (bus.ena) begin
            for (int c = 0; c < NCH; c++) begin
                if (capture) cap[c] <= bus.x[SGL_W*c +: SGL_W];
                if (res_valid && res_tag == CNT_W'(c)) ybank[c] <= res_data;
            end
        end
    end

    sgl2ext_core #(
        .TAG_W       (CNT_W),
        .DENORM_NORM (DENORM_NORM)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.ena),
        .in_valid  (issue),
        .in_tag    (cnt),
        .in_data   (cap[cnt]),
        .s1_busy   (s1_busy),
        .out_valid (res_valid),
        .out_tag   (res_tag),
        .out_data  (res_data)
    );

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ypack
            assign bus.y[EXT_W*c +: EXT_W] = ybank[c];
        end
    endgenerate

    assign bus.busy     = busy_ff;
    assign bus.done_sig = done_ff;
    assign bus.sta_err  = err_ff;

endmodule
`default_nettype wire

// File: tb/tb_sgl2ext_convert_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgl2ext_convert_mc
// Brief    : Directed bench for sgl2ext_convert_mc (normalize and flush builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgl2ext_convert_mc;

    localparam int NCH = 4;
    localparam int XW  = NCH * 32;
    localparam int YW  = NCH * 43;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sgl2ext_convert_mc_if #(.NCH(NCH)) bus   ();
    sgl2ext_convert_mc_if #(.NCH(NCH)) bus_f ();

    assign bus_f.ena = bus.ena;
    assign bus_f.sta = bus.sta;
    assign bus_f.x   = bus.x;

    sgl2ext_convert_mc #(.NCH(NCH), .DENORM_NORM(1)) dut   (.clk(clk), .rst(rst), .bus(bus));
    sgl2ext_convert_mc #(.NCH(NCH), .DENORM_NORM(0)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    logic [YW-1:0] q_n[$];
    logic [YW-1:0] q_f[$];

    function automatic logic [42:0] ref_conv(input logic [31:0] f, input bit norm);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m, mm;
        int          sh;
        s = f[31]; e = f[30:23]; m = f[22:0];
        if (e == 8'hFF) begin
            if (m == 0) return {s, 11'h7FF, 31'd0};
            return {s, 11'h7FF, 1'b1, m[21:0], 8'h00};
        end
        if (e == 8'h00) begin
            if (m == 0 || !norm) return {s, 42'd0};
            mm = m; sh = 0;
            while (mm[22] == 1'b0) begin mm = mm << 1; sh++; end
            return {s, 11'(896 - sh), mm[21:0], 9'd0};
        end
        return {s, 11'(int'(e) + 896), m, 8'h00};
    endfunction

    function automatic logic [YW-1:0] ref_vec(input logic [XW-1:0] xv, input bit norm);
        logic [YW-1:0] r;
        for (int c = 0; c < NCH; c++) r[43*c +: 43] = ref_conv(xv[32*c +: 32], norm);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [XW-1:0] xv, input bit push);
        bus.x   = xv;
        bus.sta = 1'b1;
        if (push) begin
            q_n.push_back(ref_vec(xv, 1'b1));
            q_f.push_back(ref_vec(xv, 1'b0));
        end
        tick();
        bus.sta = 1'b0;
        bus.x   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic await_done(input string tag, input int exp_edge);
        int i;
        i = 0;
        while (bus.done_sig !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        chk({tag, " done edge"}, 256'(edge_n), 256'(exp_edge));
        if (q_n.size() > 0) begin
            chk({tag, " y"}, 256'(bus.y), 256'(q_n.pop_front()));
            chk({tag, " y flush"}, 256'(bus_f.y), 256'(q_f.pop_front()));
        end else begin
            n_vec++;
            n_err++;
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
        end
    endtask

    initial begin
        int k;
        bit seen;
        logic [XW-1:0] xr;
        bus.ena = 1'b1;
        bus.sta = 1'b0;
        bus.x   = '0;
        rst     = 1'b1;
        tick();
        tick();
        chk("reset y", 256'(bus.y), 256'(0));
        chk("reset busy", 256'(bus.busy), 256'(0));
        chk("reset done", 256'(bus.done_sig), 256'(0));
        chk("reset sta_err", 256'(bus.sta_err), 256'(0));
        rst = 1'b0;
        tick();

        // Basic batch with literal expectations
        launch({32'h80000000, 32'h00000000, 32'hC0200000, 32'h3F800000}, 1'b1);
        k = edge_n;
        chk("A busy", 256'(bus.busy), 256'(1));
        await_done("A", k + 6);
        chk("A literal", 256'(bus.y),
            256'({43'h40000000000, 43'h0, 43'h60020000000, 43'h1FF80000000}));
        chk("A busy low", 256'(bus.busy), 256'(0));
        tick();
        chk("A done falls", 256'(bus.done_sig), 256'(0));

        // Specials and smallest denormal
        launch({32'h00000001, 32'hFF800000, 32'h7F800001, 32'h7F800000}, 1'b1);
        k = edge_n;
        await_done("B", k + 6);
        chk("B literal", 256'(bus.y),
            256'({43'h1B500000000, 43'h7FF80000000, 43'h3FFC0000100, 43'h3FF80000000}));
        chk("B flush literal", 256'(bus_f.y),
            256'({43'h0, 43'h7FF80000000, 43'h3FFC0000100, 43'h3FF80000000}));
        tick();

        // Largest denormal exponent, negative denormal, quiet NaN
        launch({32'h7FC00000, 32'h3F800000, 32'h80000001, 32'h00400000}, 1'b1);
        k = edge_n;
        await_done("C", k + 6);
        chk("C ch0 literal", 256'(bus.y[42:0]), 256'(43'h1C000000000));
        chk("C ch0 flush", 256'(bus_f.y[42:0]), 256'(0));
        tick();

        for (int r = 0; r < 3; r++) begin
            xr = {$urandom, $urandom, $urandom, $urandom};
            launch(xr, 1'b1);
            k = edge_n;
            await_done("R", k + 6);
            tick();
        end

        // Overrun then chained start on the completing edge
        launch({32'h40490FDB, 32'h00012345, 32'hBF000000, 32'h7F7FFFFF}, 1'b1);
        k = edge_n;
        tick();
        bus.sta = 1'b1;
        bus.x   = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tick();
        bus.sta = 1'b0;
        chk("overrun sta_err", 256'(bus.sta_err), 256'(1));
        tick();
        chk("overrun sta_err clears", 256'(bus.sta_err), 256'(0));
        tick();
        tick();
        xr = {32'hC2F6E979, 32'h807FFFFF, 32'hFFFFFFFF, 32'h00800000};
        bus.x   = xr;
        bus.sta = 1'b1;
        q_n.push_back(ref_vec(xr, 1'b1));
        q_f.push_back(ref_vec(xr, 1'b0));
        await_done("D", k + 6);
        bus.sta = 1'b0;
        chk("chain no sta_err", 256'(bus.sta_err), 256'(0));
        chk("chain busy", 256'(bus.busy), 256'(1));
        tick();
        await_done("E", k + 12);
        chk("E busy low", 256'(bus.busy), 256'(0));
        tick();

        // ena low for three edges mid-issue
        launch({32'h3E800000, 32'hC1200000, 32'h00000003, 32'h3F000000}, 1'b1);
        k = edge_n;
        tick();
        tick();
        bus.ena = 1'b0;
        tick();
        tick();
        tick();
        chk("freeze busy", 256'(bus.busy), 256'(1));
        bus.ena = 1'b1;
        await_done("F", k + 9);
        tick();

        // ena low while done_sig is up
        launch({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 1'b1);
        k = edge_n;
        await_done("G", k + 6);
        bus.ena = 1'b0;
        tick();
        tick();
        chk("done stretched", 256'(bus.done_sig), 256'(1));
        bus.ena = 1'b1;
        tick();
        chk("done clears", 256'(bus.done_sig), 256'(0));

        // Reset mid-batch aborts it
        launch({32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000}, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort y", 256'(bus.y), 256'(0));
        chk("abort y flush", 256'(bus_f.y), 256'(0));
        chk("abort busy", 256'(bus.busy), 256'(0));
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (bus.done_sig === 1'b1) seen = 1'b1;
        end
        chk("abort no done", 256'(seen), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
